// File: rtl/bank_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM bank between NUM_REQ requesters.
// Supports locked bursts and routes one-cycle-latency read data back to the issuer.
module bank_ram_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // Handshake: a command transfers in any cycle where req_valid[i] && req_ready[i].
  // req_ready is combinational on req_valid; a requester holds valid and fields
  // stable until ready and must not derive req_valid from req_ready.
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  input  logic [DATA_WIDTH-1:0]         ram_rdata
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      lock_owner_q, lock_owner_d;
  logic               lock_active_q, lock_active_d;
  logic [NUM_REQ-1:0] rsp_sel_q, rsp_sel_d;

  logic               grant_valid;
  logic [IW-1:0]      grant_idx;
  logic               found;
  int unsigned        cand;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    found       = 1'b0;
    cand        = 0;
    if (lock_active_q) begin
      // The bank stays reserved for the owner even while it is idle.
      if (req_valid[lock_owner_q]) begin
        grant_valid = 1'b1;
        grant_idx   = lock_owner_q;
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = {{(32-IW){1'b0}}, rr_ptr_q} + unsigned'(k);
        if (cand >= unsigned'(NUM_REQ)) cand = cand - unsigned'(NUM_REQ);
        if (!found && req_valid[cand[IW-1:0]]) begin
          found     = 1'b1;
          grant_idx = cand[IW-1:0];
        end
      end
      grant_valid = found;
    end
    // No command may be granted while reset is asserted.
    if (!rst_n) grant_valid = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (grant_valid) begin
      req_ready[grant_idx] = 1'b1;
      ram_en    = 1'b1;
      ram_we    = req_we[grant_idx];
      ram_addr  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
      ram_wdata = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    lock_owner_d  = lock_owner_q;
    lock_active_d = lock_active_q;
    rsp_sel_d     = '0;
    if (grant_valid) begin
      rr_ptr_d      = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
      lock_owner_d  = grant_idx;
      lock_active_d = req_lock[grant_idx];
      if (!req_we[grant_idx]) rsp_sel_d[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      lock_owner_q  <= '0;
      lock_active_q <= 1'b0;
      rsp_sel_q     <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      lock_owner_q  <= lock_owner_d;
      lock_active_q <= lock_active_d;
      rsp_sel_q     <= rsp_sel_d;
    end
  end

  assign rsp_valid = rsp_sel_q;
  assign rsp_rdata = ram_rdata;

endmodule

// File: tb/tb_bank_ram_arbiter.sv
// Directed table-driven bench for bank_ram_arbiter with a behavioural single-port RAM.
module tb_bank_ram_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 64;

  typedef struct {
    logic [N-1:0]    valid;
    logic [N-1:0]    we;
    logic [N-1:0]    lock;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    exp_ready;
    logic            exp_en;
    logic            exp_we;
    logic [AW-1:0]   exp_addr;
    logic [DW-1:0]   exp_wdata;
    logic [N-1:0]    exp_rsp;
    logic [DW-1:0]   exp_rdata;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, ram_wdata, ram_rdata;
  logic            ram_en, ram_we;
  logic [AW-1:0]   ram_addr;

  logic [DW-1:0]   mem [0:(1<<AW)-1];
  int              n_cmp = 0;
  int              n_fail = 0;
  vec_t            vecs[$];

  localparam logic [DW-1:0] BASE = 64'hC0DE_0000_0000_0000;
  localparam logic [DW-1:0] W1   = 64'h1111_2222_3333_0001;
  localparam logic [DW-1:0] W2   = 64'h1111_2222_3333_0002;
  localparam logic [DW-1:0] W3   = 64'h1111_2222_3333_0003;

  bank_ram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Behavioural bank RAM: registered read, write without read update
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  function automatic logic [N*AW-1:0] pa(input logic [AW-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [N*DW-1:0] pd(input logic [DW-1:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  function automatic vec_t mkv(
    input logic [N-1:0] v, w, l, input logic [N*AW-1:0] a, input logic [N*DW-1:0] d,
    input logic [N-1:0] er, input logic een, ewe, input logic [AW-1:0] ea,
    input logic [DW-1:0] ed, input logic [N-1:0] ers, input logic [DW-1:0] erd);
    vec_t t;
    t.valid = v; t.we = w; t.lock = l; t.addr = a; t.wdata = d;
    t.exp_ready = er; t.exp_en = een; t.exp_we = ewe; t.exp_addr = ea;
    t.exp_wdata = ed; t.exp_rsp = ers; t.exp_rdata = erd;
    return t;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [N-1:0] v, w, l, input logic [N*AW-1:0] a,
                       input logic [N*DW-1:0] d);
    req_valid = v; req_we = w; req_lock = l; req_addr = a; req_wdata = d;
  endtask

  task automatic apply_vec(input int idx, input vec_t t);
    string s;
    @(posedge clk); #1;
    drive(t.valid, t.we, t.lock, t.addr, t.wdata);
    #3;
    s = $sformatf("v%0d", idx);
    check({s, ".req_ready"}, DW'(req_ready), DW'(t.exp_ready));
    check({s, ".ram_en"},    DW'(ram_en),    DW'(t.exp_en));
    check({s, ".ram_we"},    DW'(ram_we),    DW'(t.exp_we));
    check({s, ".ram_addr"},  DW'(ram_addr),  DW'(t.exp_addr));
    check({s, ".ram_wdata"}, ram_wdata,      t.exp_wdata);
    check({s, ".rsp_valid"}, DW'(rsp_valid), DW'(t.exp_rsp));
    if (t.exp_rsp != '0) check({s, ".rsp_rdata"}, rsp_rdata, t.exp_rdata);
  endtask

  logic [N*AW-1:0] a_rr;
  logic [N*DW-1:0] d0;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = BASE | DW'(i);
    mem[5] = 64'hA5;
    a_rr = pa(10'h020, 10'h021, 10'h022, 10'h023);
    d0   = '0;

    // Reset with every requester asserting valid: nothing may be granted
    rst_n = 1'b0;
    drive(4'b1111, 4'b0000, 4'b0000, a_rr, d0);
    repeat (2) @(posedge clk);
    #1;
    check("reset.req_ready", DW'(req_ready), '0);
    check("reset.ram_en",    DW'(ram_en),    '0);
    check("reset.rsp_valid", DW'(rsp_valid), '0);
    drive(4'b0000, 4'b0000, 4'b0000, a_rr, d0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single read by requester 2
    vecs.push_back(mkv(4'b0100, 4'b0000, 4'b0000, pa(0, 0, 10'h005, 0), d0,
                       4'b0100, 1, 0, 10'h005, '0, 4'b0000, '0));
    vecs.push_back(mkv(4'b0000, 4'b0000, 4'b0000, '0, d0,
                       4'b0000, 0, 0, '0, '0, 4'b0100, 64'hA5));
    // Requester 3 read moves the pointer round to 0
    vecs.push_back(mkv(4'b1000, 4'b0000, 4'b0000, pa(0, 0, 0, 10'h010), d0,
                       4'b1000, 1, 0, 10'h010, '0, 4'b0000, '0));
    // Fairness: all four hold reads
    vecs.push_back(mkv(4'b1111, 4'b0000, 4'b0000, a_rr, d0,
                       4'b0001, 1, 0, 10'h020, '0, 4'b1000, BASE | 64'h10));
    vecs.push_back(mkv(4'b1111, 4'b0000, 4'b0000, a_rr, d0,
                       4'b0010, 1, 0, 10'h021, '0, 4'b0001, BASE | 64'h20));
    vecs.push_back(mkv(4'b1111, 4'b0000, 4'b0000, a_rr, d0,
                       4'b0100, 1, 0, 10'h022, '0, 4'b0010, BASE | 64'h21));
    vecs.push_back(mkv(4'b1111, 4'b0000, 4'b0000, a_rr, d0,
                       4'b1000, 1, 0, 10'h023, '0, 4'b0100, BASE | 64'h22));
    vecs.push_back(mkv(4'b1111, 4'b0000, 4'b0000, a_rr, d0,
                       4'b0001, 1, 0, 10'h020, '0, 4'b1000, BASE | 64'h23));
    vecs.push_back(mkv(4'b0000, 4'b0000, 4'b0000, a_rr, d0,
                       4'b0000, 0, 0, '0, '0, 4'b0001, BASE | 64'h20));
    // Write by requester 1 then read of the same address by requester 3
    vecs.push_back(mkv(4'b0010, 4'b0010, 4'b0000, pa(0, 10'h3FF, 0, 0),
                       pd(0, 64'hDEADBEEF, 0, 0),
                       4'b0010, 1, 1, 10'h3FF, 64'hDEADBEEF, 4'b0000, '0));
    vecs.push_back(mkv(4'b1000, 4'b0000, 4'b0000, pa(0, 0, 0, 10'h3FF), d0,
                       4'b1000, 1, 0, 10'h3FF, '0, 4'b0000, '0));
    vecs.push_back(mkv(4'b0000, 4'b0000, 4'b0000, '0, d0,
                       4'b0000, 0, 0, '0, '0, 4'b1000, 64'hDEADBEEF));
    // Locked burst by requester 0 with requester 1 waiting; owner idles once
    vecs.push_back(mkv(4'b0011, 4'b0001, 4'b0001, pa(10'h100, 10'h030, 0, 0), pd(W1, 0, 0, 0),
                       4'b0001, 1, 1, 10'h100, W1, 4'b0000, '0));
    vecs.push_back(mkv(4'b0011, 4'b0001, 4'b0001, pa(10'h101, 10'h030, 0, 0), pd(W2, 0, 0, 0),
                       4'b0001, 1, 1, 10'h101, W2, 4'b0000, '0));
    vecs.push_back(mkv(4'b0010, 4'b0000, 4'b0000, pa(0, 10'h030, 0, 0), d0,
                       4'b0000, 0, 0, '0, '0, 4'b0000, '0));
    vecs.push_back(mkv(4'b0011, 4'b0001, 4'b0000, pa(10'h102, 10'h030, 0, 0), pd(W3, 0, 0, 0),
                       4'b0001, 1, 1, 10'h102, W3, 4'b0000, '0));
    vecs.push_back(mkv(4'b0010, 4'b0000, 4'b0000, pa(0, 10'h030, 0, 0), d0,
                       4'b0010, 1, 0, 10'h030, '0, 4'b0000, '0));
    vecs.push_back(mkv(4'b0100, 4'b0000, 4'b0000, pa(0, 0, 10'h101, 0), d0,
                       4'b0100, 1, 0, 10'h101, '0, 4'b0010, BASE | 64'h30));
    vecs.push_back(mkv(4'b0000, 4'b0000, 4'b0000, '0, d0,
                       4'b0000, 0, 0, '0, '0, 4'b0100, W2));

    foreach (vecs[i]) apply_vec(i, vecs[i]);

    // Reset in the middle of a burst by requester 1 with a read in flight
    @(posedge clk); #1;
    drive(4'b0010, 4'b0010, 4'b0010, pa(0, 10'h040, 0, 0), pd(0, W1, 0, 0));
    #3;
    check("burst.write_ready", DW'(req_ready), DW'(4'b0010));
    @(posedge clk); #1;
    drive(4'b0010, 4'b0000, 4'b0010, pa(0, 10'h020, 0, 0), d0);
    #3;
    check("burst.read_ready", DW'(req_ready), DW'(4'b0010));
    @(posedge clk); #1;
    check("burst.rsp_before_reset", DW'(rsp_valid), DW'(4'b0010));
    rst_n = 1'b0;
    #1;
    check("midrst.rsp_valid", DW'(rsp_valid), '0);
    check("midrst.req_ready", DW'(req_ready), '0);
    check("midrst.ram_en",    DW'(ram_en),    '0);
    #1;
    rst_n = 1'b1;
    drive(4'b1111, 4'b0000, 4'b0000, a_rr, d0);
    #1;
    check("post_rst.ready0",   DW'(req_ready), DW'(4'b0001));
    check("post_rst.rsp_none", DW'(rsp_valid), '0);
    @(posedge clk); #1;
    check("post_rst.ready1", DW'(req_ready), DW'(4'b0010));
    check("post_rst.rsp0",   DW'(rsp_valid), DW'(4'b0001));
    check("post_rst.rdata0", rsp_rdata, BASE | 64'h20);
    @(posedge clk); #1;
    drive(4'b0000, 4'b0000, 4'b0000, a_rr, d0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
